cond_unit: RTL and testbench
============================

# cond_unit

Execute-stage condition and flag unit of the ARMv4 core, sitting directly downstream of the ALU. It holds the architectural CNVZ flag register and feeds it back to the ALU's CNVZI input. It evaluates the 4-bit ARM condition field of the instruction in execute against the current flags. It then registers the ALU result and the condition-gated write strobes into the execute/writeback pipeline register, with stall and flush support.

## Interface

Parameters:
- BUS, 32, datapath width of alu_result / out_result

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction present in execute
- cond  in  4  ARM condition field (instr[31:28])
- flag_w  in  2  [1]: update N,Z; [0]: update C,V
- alu_flags  in  4  ALU CNVZO: [3]=C [2]=N [1]=V [0]=Z
- alu_result  in  BUS  ALU output s
- rd  in  4  destination register index
- reg_write_in, mem_write_in, pc_src_in  in  1 each  decoder strobes
- stall  in  1  hold pipeline register and flags
- flush  in  1  kill instruction in execute
- flags  out  4  architectural CNVZ, same bit order, to ALU CNVZI
- cond_ex  out  1  combinational: condition passes for current cond/flags
- out_valid  out  1  registered valid
- out_result  out  BUS  registered alu_result
- out_rd  out  4  registered rd
- reg_write, mem_write, pc_src  out  1 each  registered, condition-gated strobes

## Operation

- Condition evaluation is combinational and uses the flags register value, never alu_flags.
- Conditions: EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 true; 1111 (NV) false.
- accept = in_valid & ~stall & ~flush.
- Flag write on accept & cond_ex:
  - flag_w[1]: N,Z ← alu_flags[2],[0].
  - flag_w[0]: C,V ← alu_flags[3],[1].
  - Either bit may be set alone or both together; unselected flags hold.
- Pipeline register priority, highest first:
  - flush: out_valid←0, all strobes←0, out_result and out_rd hold.
  - stall: all outputs hold.
  - otherwise: out_valid←in_valid, out_result←alu_result, out_rd←rd, each strobe←strobe_in & cond_ex & in_valid.
- A failed-condition instruction still retires: out_valid=1 with all strobes 0.
- flush and stall together: flush wins; flags are not written.

## Timing

- Reset (async, rst_n=0): flags=4'b0000; out_valid, reg_write, mem_write, pc_src = 0; out_result=0; out_rd=0. Takes effect immediately, without waiting for clk.
- Reset deasserted mid-stream: first accepted instruction evaluates against all-zero flags.
- Pipeline register latency: 1 cycle.
- Flag latency: 1 cycle. A flag write from instruction i is visible to instruction i+1 in the next cycle, so back-to-back CMP→BEQ needs no bubble.
- cond_ex has zero latency (combinational from cond and flags).
- A stalled cycle neither accepts nor writes flags. Upstream holds its inputs during stall.

## Configuration

- COND_STATS_EN defined:
  - Adds ports exec_count out 16 and skip_count out 16.
  - On each accept, exec_count increments if cond_ex is true; otherwise skip_count increments.
  - Both counters saturate at 16'hFFFF and reset to 0.
- COND_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Structure

- Package cond_pkg:
  - cond_e enum for the 16 condition encodings.
  - Flag bit index constants FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0.
- Sub-module cond_check: purely combinational (cond, flags) → pass, instantiated once.
- Flag register, pipeline register and optional counters live in cond_unit.

## Test plan

- Reset: rst_n=0 asynchronously mid-cycle → flags=0000 and out_valid=0 immediately; cond=0000 (EQ) → cond_ex=0; cond=1110 → cond_ex=1.
- Flag update: cond=AL, flag_w=11, alu_flags=4'b0001 → next cycle flags=0001; following cond=EQ with reg_write_in=1 → reg_write=1 one cycle later.
- Partial update: flags=1111, flag_w=10, alu_flags=0000 → flags=1010 (C,V kept).
- Condition fail: flags=0000, cond=NE is not a fail case, so use cond=EQ with reg_write_in=1, mem_write_in=1 → out_valid=1, reg_write=0, mem_write=0, flags unchanged despite flag_w=11.
- Stall/flush: stall=1 for 2 cycles → outputs and flags frozen. Then flush=1 with stall=1 → out_valid=0, flags unchanged.
- COND_STATS_EN: 3 passing and 2 failing accepts, plus 1 stalled cycle → exec_count=3, skip_count=2; force 70000 passes → exec_count=16'hFFFF.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg -- shared definitions for the execute-stage condition/flag unit.
//
// Contents:
//   cond_e        : the sixteen ARM condition-field encodings (instr[31:28])
//   FLAG_C/N/V/Z  : bit positions of each flag inside the 4-bit CNVZ vector
//   cnvz_t        : the CNVZ vector as a plain 4-bit type
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Flag ordering matches the ALU's CNVZ output and CNVZI input.
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [3:0] cnvz_t;

endpackage

// File: rtl/cond_check.sv
// cond_check -- purely combinational ARM condition evaluator.
//
// Ports:
//   cond_i  [3:0] : condition field of the instruction in execute
//   flags_i [3:0] : architectural CNVZ flags ([3]=C [2]=N [1]=V [0]=Z)
//   pass_o        : 1 when the instruction should take effect
module cond_check
  import cond_pkg::*;
(
  input  logic  [3:0] cond_i,
  input  cnvz_t       flags_i,
  output logic        pass_o
);

  logic c;
  logic n;
  logic v;
  logic z;

  assign c = flags_i[FLAG_C];
  assign n = flags_i[FLAG_N];
  assign v = flags_i[FLAG_V];
  assign z = flags_i[FLAG_Z];

  // Decode the condition field against the current flags. NV is treated
  // as "never", so an instruction carrying it always retires as a no-op.
  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit -- execute-stage condition and flag unit of the ARMv4 core.
//
// Holds the CNVZ flag register (fed back to the ALU), evaluates the
// instruction's condition field against it, and registers the ALU result
// plus condition-gated write strobes into the execute/writeback register.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid              : instruction present in execute
//   cond [3:0]            : ARM condition field
//   flag_w [1:0]          : [1] update N,Z  [0] update C,V
//   alu_flags [3:0]       : ALU CNVZ result
//   alu_result [BUS-1:0]  : ALU data result
//   rd [3:0]              : destination register index
//   reg_write_in, mem_write_in, pc_src_in : decoder strobes
//   stall, flush          : pipeline hold / kill
//   flags [3:0]           : architectural CNVZ to ALU
//   cond_ex               : combinational condition pass
//   out_valid, out_result, out_rd, reg_write, mem_write, pc_src : EX/WB register
//
// Optional build macro COND_STATS_EN adds exec_count/skip_count [15:0],
// saturating counters of accepted instructions whose condition passed/failed.
module cond_unit
  import cond_pkg::*;
#(
  parameter int BUS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [3:0]     cond,
  input  logic [1:0]     flag_w,
  input  logic [3:0]     alu_flags,
  input  logic [BUS-1:0] alu_result,
  input  logic [3:0]     rd,
  input  logic           reg_write_in,
  input  logic           mem_write_in,
  input  logic           pc_src_in,
  input  logic           stall,
  input  logic           flush,
  output logic [3:0]     flags,
  output logic           cond_ex,
  output logic           out_valid,
  output logic [BUS-1:0] out_result,
  output logic [3:0]     out_rd,
  output logic           reg_write,
  output logic           mem_write,
  output logic           pc_src
`ifdef COND_STATS_EN
  ,
  output logic [15:0]    exec_count,
  output logic [15:0]    skip_count
`endif
);

  logic           accept;
  cnvz_t          flags_q;
  cnvz_t          flags_d;
  logic           valid_q;
  logic           valid_d;
  logic [BUS-1:0] result_q;
  logic [BUS-1:0] result_d;
  logic [3:0]     rd_q;
  logic [3:0]     rd_d;
  logic           regw_q;
  logic           regw_d;
  logic           memw_q;
  logic           memw_d;
  logic           pcsrc_q;
  logic           pcsrc_d;

  // Conditions always look at the committed flag register, never at the
  // ALU's fresh flags, so an instruction cannot gate itself.
  cond_check u_cond_check (
    .cond_i  (cond),
    .flags_i (flags_q),
    .pass_o  (cond_ex)
  );

  assign accept = in_valid & ~stall & ~flush;

  // Flag register next state: the two flag_w bits select independent
  // halves (N,Z and C,V); anything not selected keeps its old value.
  always_comb begin
    flags_d = flags_q;
    if (accept && cond_ex) begin
      if (flag_w[1]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  // EX/WB register next state. Flush beats stall; on flush only the
  // valid bit and strobes are cleared, the data fields are left as-is
  // because nothing downstream looks at them without valid.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    regw_d   = regw_q;
    memw_d   = memw_q;
    pcsrc_d  = pcsrc_q;
    if (flush) begin
      valid_d = 1'b0;
      regw_d  = 1'b0;
      memw_d  = 1'b0;
      pcsrc_d = 1'b0;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = alu_result;
      rd_d     = rd;
      regw_d   = reg_write_in & cond_ex & in_valid;
      memw_d   = mem_write_in & cond_ex & in_valid;
      pcsrc_d  = pc_src_in & cond_ex & in_valid;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      pcsrc_q  <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      pcsrc_q  <= pcsrc_d;
    end
  end

  assign flags      = flags_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign reg_write  = regw_q;
  assign mem_write  = memw_q;
  assign pc_src     = pcsrc_q;

`ifdef COND_STATS_EN
  logic [15:0] exec_q;
  logic [15:0] exec_d;
  logic [15:0] skip_q;
  logic [15:0] skip_d;

  // Per-accept statistics; each counter sticks at all-ones instead of
  // wrapping so long runs never report a misleadingly small number.
  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (accept) begin
      if (cond_ex) begin
        if (exec_q != 16'hFFFF) exec_d = exec_q + 16'd1;
      end else begin
        if (skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign exec_count = exec_q;
  assign skip_count = skip_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit -- scoreboard testbench for cond_unit.
// Each drive pushes the expected EX/WB register + flags onto a queue;
// after the clock edge the test pops it and compares with the DUT.
module tb_cond_unit;

  localparam int BUS = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [3:0]     cond;
  logic [1:0]     flag_w;
  logic [3:0]     alu_flags;
  logic [BUS-1:0] alu_result;
  logic [3:0]     rd;
  logic           reg_write_in;
  logic           mem_write_in;
  logic           pc_src_in;
  logic           stall;
  logic           flush;
  logic [3:0]     flags;
  logic           cond_ex;
  logic           out_valid;
  logic [BUS-1:0] out_result;
  logic [3:0]     out_rd;
  logic           reg_write;
  logic           mem_write;
  logic           pc_src;
`ifdef COND_STATS_EN
  logic [15:0]    exec_count;
  logic [15:0]    skip_count;
`endif

  typedef struct packed {
    logic           valid;
    logic [BUS-1:0] result;
    logic [3:0]     rd;
    logic           rw;
    logic           mw;
    logic           pc;
    logic [3:0]     flags;
  } obs_t;

  obs_t       sbQ[$];
  obs_t       mOut;
  logic [3:0] mFlags;
  logic       expCondEx;
  obs_t       exp;
  obs_t       act;
  int         checks;
  int         passes;

  cond_unit #(.BUS(BUS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .cond         (cond),
    .flag_w       (flag_w),
    .alu_flags    (alu_flags),
    .alu_result   (alu_result),
    .rd           (rd),
    .reg_write_in (reg_write_in),
    .mem_write_in (mem_write_in),
    .pc_src_in    (pc_src_in),
    .stall        (stall),
    .flush        (flush),
    .flags        (flags),
    .cond_ex      (cond_ex),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .pc_src       (pc_src)
`ifdef COND_STATS_EN
    ,
    .exec_count   (exec_count),
    .skip_count   (skip_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition table, written directly from the ARM definitions.
  function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
    logic fc, fn, fv, fz;
    fc = f[3]; fn = f[2]; fv = f[1]; fz = f[0];
    case (c)
      4'h0: modelCond = fz;
      4'h1: modelCond = !fz;
      4'h2: modelCond = fc;
      4'h3: modelCond = !fc;
      4'h4: modelCond = fn;
      4'h5: modelCond = !fn;
      4'h6: modelCond = fv;
      4'h7: modelCond = !fv;
      4'h8: modelCond = fc && !fz;
      4'h9: modelCond = !fc || fz;
      4'hA: modelCond = (fn == fv);
      4'hB: modelCond = (fn != fv);
      4'hC: modelCond = !fz && (fn == fv);
      4'hD: modelCond = fz || (fn != fv);
      4'hE: modelCond = 1'b1;
      default: modelCond = 1'b0;
    endcase
  endfunction

  function automatic obs_t observed();
    observed = {out_valid, out_result, out_rd, reg_write, mem_write, pc_src, flags};
  endfunction

  task automatic resetModel();
    mOut   = '0;
    mFlags = 4'b0000;
    sbQ.delete();
  endtask

  // Drive one instruction, advance the model and push the expectation.
  task automatic driveCycle(input logic v, input logic [3:0] c, input logic [1:0] fw,
                            input logic [3:0] af, input logic [BUS-1:0] res,
                            input logic [3:0] r, input logic rwi, input logic mwi,
                            input logic pci, input logic st, input logic fl);
    obs_t nxt;
    logic pass;
    in_valid = v; cond = c; flag_w = fw; alu_flags = af; alu_result = res;
    rd = r; reg_write_in = rwi; mem_write_in = mwi; pc_src_in = pci;
    stall = st; flush = fl;
    pass = modelCond(c, mFlags);
    expCondEx = pass;
    nxt = mOut;
    if (fl) begin
      nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mw = 1'b0; nxt.pc = 1'b0;
    end else if (!st) begin
      nxt.valid = v; nxt.result = res; nxt.rd = r;
      nxt.rw = rwi & pass & v; nxt.mw = mwi & pass & v; nxt.pc = pci & pass & v;
    end
    if (v && !st && !fl && pass) begin
      if (fw[1]) begin mFlags[2] = af[2]; mFlags[0] = af[0]; end
      if (fw[0]) begin mFlags[3] = af[3]; mFlags[1] = af[1]; end
    end
    nxt.flags = mFlags;
    mOut = nxt;
    sbQ.push_back(nxt);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; cond = 4'h0; flag_w = 0; alu_flags = 0; alu_result = 0; rd = 0;
    reg_write_in = 0; mem_write_in = 0; pc_src_in = 0; stall = 0; flush = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    resetModel();
    #1;
    act = observed(); checks++;
    if (act !== mOut) $display("[TB] FAIL reset_async: got %h expected %h", act, mOut);
    else passes++;
    checks++;
    if (cond_ex !== modelCond(4'h0, mFlags)) $display("[TB] FAIL reset_eq: got %b expected 0", cond_ex);
    else passes++;
    @(negedge clk);
    cond = 4'hE; #1;
    checks++;
    if (cond_ex !== 1'b1) $display("[TB] FAIL reset_al: got %b expected 1", cond_ex);
    else passes++;
    cond = 4'hF; #1;
    checks++;
    if (cond_ex !== 1'b0) $display("[TB] FAIL reset_nv: got %b expected 0", cond_ex);
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_flag_update();
    driveCycle(1, 4'hE, 2'b11, 4'b0001, 32'h1111_0001, 4'd1, 0, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || flags !== 4'b0001) $display("[TB] FAIL flag_update: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'h0, 2'b00, 4'b0000, 32'h2222_0002, 4'd2, 1, 0, 0, 0, 0);
    checks++;
    if (cond_ex !== 1'b1) $display("[TB] FAIL flag_beq_cond: got %b expected 1", cond_ex);
    else passes++;
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || reg_write !== 1'b1) $display("[TB] FAIL flag_beq_write: got %h expected %h", act, exp);
    else passes++;
  endtask

  task automatic test_partial();
    driveCycle(1, 4'hE, 2'b11, 4'b1111, 32'h3, 4'd3, 0, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL partial_set: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'hE, 2'b10, 4'b0000, 32'h4, 4'd4, 0, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || flags !== 4'b1010) $display("[TB] FAIL partial_nz: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'hE, 2'b01, 4'b0000, 32'h5, 4'd5, 0, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || flags !== 4'b0000) $display("[TB] FAIL partial_cv: got %h expected %h", act, exp);
    else passes++;
  endtask

  task automatic test_cond_table();
    logic [2:0] strobes;
    for (int f = 0; f < 16; f++) begin
      driveCycle(1, 4'hE, 2'b11, 4'(f), $urandom, 4'(f), 0, 0, 0, 0, 0);
      tick();
      exp = sbQ.pop_front(); act = observed(); checks++;
      if (act !== exp) $display("[TB] FAIL table_setflags f=%0d: got %h expected %h", f, act, exp);
      else passes++;
      for (int c = 0; c < 16; c++) begin
        strobes = 3'($urandom);
        driveCycle(1, 4'(c), 2'b00, 4'(~f), $urandom, 4'(c), strobes[0], strobes[1], strobes[2], 0, 0);
        checks++;
        if (cond_ex !== expCondEx)
          $display("[TB] FAIL table_cond f=%0d c=%0d: got %b expected %b", f, c, cond_ex, expCondEx);
        else passes++;
        tick();
        exp = sbQ.pop_front(); act = observed(); checks++;
        if (act !== exp) $display("[TB] FAIL table_out f=%0d c=%0d: got %h expected %h", f, c, act, exp);
        else passes++;
      end
    end
  endtask

  task automatic test_cond_fail();
    driveCycle(1, 4'hE, 2'b11, 4'b0000, 32'h6, 4'd6, 0, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL fail_setup: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'h0, 2'b11, 4'b1111, 32'h7, 4'd7, 1, 1, 0, 0, 0);
    checks++;
    if (cond_ex !== 1'b0) $display("[TB] FAIL fail_cond: got %b expected 0", cond_ex);
    else passes++;
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || out_valid !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0 || flags !== 4'b0000)
      $display("[TB] FAIL fail_retire: got %h expected %h", act, exp);
    else passes++;
  endtask

  task automatic test_stall_flush();
    driveCycle(1, 4'hE, 2'b11, 4'b0101, 32'hAAAA_0001, 4'd8, 1, 1, 1, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL sf_load: got %h expected %h", act, exp);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      driveCycle(1, 4'hE, 2'b11, 4'b1010, 32'hBBBB_0002, 4'd9, 1, 1, 1, 1, 0);
      tick();
      exp = sbQ.pop_front(); act = observed(); checks++;
      if (act !== exp) $display("[TB] FAIL sf_stall%0d: got %h expected %h", i, act, exp);
      else passes++;
    end
    driveCycle(1, 4'hE, 2'b11, 4'b1010, 32'hBBBB_0002, 4'd9, 1, 1, 1, 1, 1);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || out_valid !== 1'b0 || flags !== 4'b0101)
      $display("[TB] FAIL sf_flush_stall: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'hE, 2'b11, 4'b1111, 32'hCCCC_0003, 4'd10, 1, 1, 1, 0, 1);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL sf_flush: got %h expected %h", act, exp);
    else passes++;
    driveCycle(0, 4'hE, 2'b11, 4'b1111, 32'hDDDD_0004, 4'd11, 1, 1, 1, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL sf_bubble: got %h expected %h", act, exp);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seqCond [6];
    logic [1:0] seqFw   [6];
    logic [3:0] seqAf   [6];
    logic       seqPc   [6];
    seqCond = '{4'hE, 4'h0, 4'hE, 4'h0, 4'h1, 4'hC};
    seqFw   = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    seqAf   = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    seqPc   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      driveCycle(1, seqCond[i], seqFw[i], seqAf[i], 32'h5000 + 32'(i), 4'(i), 0, 0, seqPc[i], 0, 0);
      checks++;
      if (cond_ex !== expCondEx) $display("[TB] FAIL b2b_cond%0d: got %b expected %b", i, cond_ex, expCondEx);
      else passes++;
      tick();
      exp = sbQ.pop_front(); act = observed(); checks++;
      if (act !== exp) $display("[TB] FAIL b2b_out%0d: got %h expected %h", i, act, exp);
      else passes++;
    end
  endtask

  task automatic test_reset_midstream();
    driveCycle(1, 4'hE, 2'b11, 4'b1111, 32'h6000, 4'd12, 1, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL mid_setup: got %h expected %h", act, exp);
    else passes++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    resetModel();
    #1;
    act = observed(); checks++;
    if (act !== mOut) $display("[TB] FAIL mid_async: got %h expected %h", act, mOut);
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    driveCycle(1, 4'h0, 2'b00, 4'b0000, 32'h6001, 4'd13, 1, 0, 0, 0, 0);
    checks++;
    if (cond_ex !== 1'b0) $display("[TB] FAIL mid_eq: got %b expected 0", cond_ex);
    else passes++;
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp) $display("[TB] FAIL mid_eq_out: got %h expected %h", act, exp);
    else passes++;
    driveCycle(1, 4'h5, 2'b00, 4'b0000, 32'h6002, 4'd14, 1, 0, 0, 0, 0);
    tick();
    exp = sbQ.pop_front(); act = observed(); checks++;
    if (act !== exp || reg_write !== 1'b1) $display("[TB] FAIL mid_pl_out: got %h expected %h", act, exp);
    else passes++;
  endtask

`ifdef COND_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst_n = 1'b0;
    resetModel();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin driveCycle(1, 4'hE, 0, 0, 32'h7000, 4'd1, 0, 0, 0, 0, 0); tick(); end
    for (int i = 0; i < 2; i++) begin driveCycle(1, 4'hF, 0, 0, 32'h7001, 4'd2, 0, 0, 0, 0, 0); tick(); end
    driveCycle(1, 4'hE, 0, 0, 32'h7002, 4'd3, 0, 0, 0, 1, 0);
    tick();
    checks++;
    if (exec_count !== 16'd3 || skip_count !== 16'd2)
      $display("[TB] FAIL stats_count: got %0d/%0d expected 3/2", exec_count, skip_count);
    else passes++;
    driveCycle(1, 4'hE, 0, 0, 32'h7003, 4'd4, 0, 0, 0, 0, 0);
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (exec_count !== 16'hFFFF || skip_count !== 16'd2)
      $display("[TB] FAIL stats_sat: got %h/%h expected ffff/0002", exec_count, skip_count);
    else passes++;
    sbQ.delete();
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    resetModel();
    test_reset();
    test_flag_update();
    test_partial();
    test_cond_table();
    test_cond_fail();
    test_stall_flush();
    test_back_to_back();
    test_reset_midstream();
`ifdef COND_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
